// File: rtl/counter_4bit_down.sv
// 4-bit synchronous presettable down counter with a programmable modulus.
// Bo flags the terminal count (cnt==0 while enabled) and feeds the next stage's en.
module counter_4bit_down #(
  parameter int unsigned MODULUS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] D,
  output logic       Qa,
  output logic       Qb,
  output logic       Qc,
  output logic       Qd,
  output logic       Bo
);

  if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
    $error("counter_4bit_down: MODULUS must be in 2..16");
  end

  localparam logic [3:0] WRAP_VAL = 4'(MODULUS - 1);
  localparam logic [4:0] MOD_5B   = 5'(MODULUS);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] load_val;

  // Out-of-range load values clamp to the top of the range so cnt never leaves 0..MODULUS-1.
  always_comb begin
    load_val = D;
    if ({1'b0, D} >= MOD_5B) begin
      load_val = WRAP_VAL;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (cnt_q == 4'd0) begin
        cnt_d = WRAP_VAL;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Qa = cnt_q[0];
  assign Qb = cnt_q[1];
  assign Qc = cnt_q[2];
  assign Qd = cnt_q[3];
  // Unregistered so a cascaded stage decrements on the same edge as this stage's wrap.
  assign Bo = en & (cnt_q == 4'd0);

endmodule

// File: tb/tb_counter_4bit_down.sv
// Directed self-checking bench for counter_4bit_down: hex, decade and two-stage cascade.
module tb_counter_4bit_down;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Hex instance
  logic       rst, en, load;
  logic [3:0] d;
  wire  [3:0] q16;
  wire        bo16;

  counter_4bit_down #(.MODULUS(16)) u_hex (
    .clk(clk), .rst(rst), .en(en), .load(load), .D(d),
    .Qa(q16[0]), .Qb(q16[1]), .Qc(q16[2]), .Qd(q16[3]), .Bo(bo16)
  );

  // Decade instance
  logic       dec_rst, dec_en, dec_load;
  logic [3:0] dec_d;
  wire  [3:0] q10;
  wire        bo10;

  counter_4bit_down #(.MODULUS(10)) u_dec (
    .clk(clk), .rst(dec_rst), .en(dec_en), .load(dec_load), .D(dec_d),
    .Qa(q10[0]), .Qb(q10[1]), .Qc(q10[2]), .Qd(q10[3]), .Bo(bo10)
  );

  // Two-stage cascade
  logic       cas_rst, lo_en;
  wire  [3:0] q_lo, q_hi;
  wire        bo_lo, bo_hi;

  counter_4bit_down #(.MODULUS(16)) u_lo (
    .clk(clk), .rst(cas_rst), .en(lo_en), .load(1'b0), .D(4'd0),
    .Qa(q_lo[0]), .Qb(q_lo[1]), .Qc(q_lo[2]), .Qd(q_lo[3]), .Bo(bo_lo)
  );

  counter_4bit_down #(.MODULUS(16)) u_hi (
    .clk(clk), .rst(cas_rst), .en(bo_lo), .load(1'b0), .D(4'd0),
    .Qa(q_hi[0]), .Qb(q_hi[1]), .Qc(q_hi[2]), .Qd(q_hi[3]), .Bo(bo_hi)
  );

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; load = 1'b0; d = 4'd0;
    tick(2);
    n_cmp++;
    if (q16 !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", q16);
    end
    n_cmp++;
    if (bo16 !== 1'b0) begin
      n_bad++; $display("FAIL reset_bo_en0: got %b want 0", bo16);
    end
    en = 1'b1;
    #1;
    n_cmp++;
    if (bo16 !== 1'b1) begin
      n_bad++; $display("FAIL reset_bo_en1: got %b want 1", bo16);
    end
    tick();
    n_cmp++;
    if (q16 !== 4'd0) begin
      n_bad++; $display("FAIL reset_holds_with_en: got %0d want 0", q16);
    end
  endtask

  task automatic test_count;
    logic [3:0] exp;
    int pulses;
    exp = 4'd0;
    pulses = 0;
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp = (exp == 4'd0) ? 4'd15 : exp - 4'd1;
      n_cmp++;
      if (q16 !== exp) begin
        n_bad++; $display("FAIL count_seq[%0d]: got %0d want %0d", i, q16, exp);
      end
      n_cmp++;
      if (bo16 !== (exp == 4'd0)) begin
        n_bad++; $display("FAIL count_bo[%0d]: got %b want %b", i, bo16, exp == 4'd0);
      end
      if (bo16 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL count_bo_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_load;
    logic [3:0] exp_seq [7];
    exp_seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
    en = 1'b0; load = 1'b1; d = 4'b0110;
    tick();
    load = 1'b0;
    n_cmp++;
    if (q16 !== 4'd6) begin
      n_bad++; $display("FAIL load_6: got %0d want 6", q16);
    end
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (q16 !== exp_seq[i]) begin
        n_bad++; $display("FAIL load_count[%0d]: got %0d want %0d", i, q16, exp_seq[i]);
      end
      n_cmp++;
      if (bo16 !== (i == 5)) begin
        n_bad++; $display("FAIL load_bo[%0d]: got %b want %b", i, bo16, i == 5);
      end
    end
  endtask

  task automatic test_load_vs_en;
    load = 1'b1; en = 1'b0; d = 4'd7;
    tick();
    n_cmp++;
    if (q16 !== 4'd7) begin
      n_bad++; $display("FAIL lve_setup7: got %0d want 7", q16);
    end
    load = 1'b1; en = 1'b1; d = 4'd3;
    tick();
    n_cmp++;
    if (q16 !== 4'd3) begin
      n_bad++; $display("FAIL load_beats_en: got %0d want 3", q16);
    end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (q16 !== 4'd3 || bo16 !== 1'b0) begin
        n_bad++; $display("FAIL hold3[%0d]: got cnt=%0d bo=%b want cnt=3 bo=0", i, q16, bo16);
      end
    end
    // Load 0 with en high: Bo must rise right after the load edge.
    load = 1'b1; en = 1'b1; d = 4'd0;
    tick();
    load = 1'b0;
    #1;
    n_cmp++;
    if (q16 !== 4'd0 || bo16 !== 1'b1) begin
      n_bad++; $display("FAIL load0_en: got cnt=%0d bo=%b want cnt=0 bo=1", q16, bo16);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (q16 !== 4'd0 || bo16 !== 1'b0) begin
        n_bad++; $display("FAIL hold0_no_wrap[%0d]: got cnt=%0d bo=%b want cnt=0 bo=0", i, q16, bo16);
      end
    end
  endtask

  task automatic test_decade;
    logic [3:0] ld_in  [5];
    logic [3:0] ld_exp [5];
    logic [3:0] exp;
    int pulses;
    ld_in  = '{4'd12, 4'd10, 4'd15, 4'd9, 4'd4};
    ld_exp = '{4'd9,  4'd9,  4'd9,  4'd9, 4'd4};
    dec_rst = 1'b1; dec_en = 1'b0; dec_load = 1'b0; dec_d = 4'd0;
    tick();
    dec_rst = 1'b0;
    n_cmp++;
    if (q10 !== 4'd0) begin
      n_bad++; $display("FAIL dec_reset: got %0d want 0", q10);
    end
    for (int i = 0; i < 5; i++) begin
      dec_load = 1'b1; dec_d = ld_in[i];
      tick();
      n_cmp++;
      if (q10 !== ld_exp[i]) begin
        n_bad++; $display("FAIL dec_load_clamp[%0d]: D=%0d got %0d want %0d", i, ld_in[i], q10, ld_exp[i]);
      end
    end
    dec_d = 4'd12;
    tick();
    dec_load = 1'b0;
    dec_en = 1'b1;
    exp = 4'd9;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (exp == 4'd0) ? 4'd9 : exp - 4'd1;
      n_cmp++;
      if (q10 !== exp) begin
        n_bad++; $display("FAIL dec_seq[%0d]: got %0d want %0d", i, q10, exp);
      end
      if (bo10 === 1'b1) pulses++;
    end
    n_cmp++;
    if (q10 !== 4'd9 || pulses != 1) begin
      n_bad++; $display("FAIL dec_wrap: got cnt=%0d pulses=%0d want cnt=9 pulses=1", q10, pulses);
    end
    dec_en = 1'b0;
  endtask

  task automatic test_cascade;
    logic [7:0] exp;
    cas_rst = 1'b1; lo_en = 1'b0;
    tick(2);
    n_cmp++;
    if ({q_hi, q_lo} !== 8'h00) begin
      n_bad++; $display("FAIL cas_reset: got %h want 00", {q_hi, q_lo});
    end
    cas_rst = 1'b0; lo_en = 1'b1;
    #1;
    n_cmp++;
    if (bo_hi !== 1'b1) begin
      n_bad++; $display("FAIL cas_bo_hi_zero: got %b want 1", bo_hi);
    end
    exp = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tick();
      exp = exp - 8'd1;
      n_cmp++;
      if ({q_hi, q_lo} !== exp || bo_hi !== (exp == 8'h00)) begin
        n_bad++; $display("FAIL cas_seq[%0d]: got %h bo_hi=%b want %h bo_hi=%b",
                          i, {q_hi, q_lo}, bo_hi, exp, exp == 8'h00);
      end
    end
    lo_en = 1'b0;
  endtask

  task automatic test_mid_reset;
    rst = 1'b0; load = 1'b1; en = 1'b0; d = 4'd8;
    tick();
    load = 1'b0; en = 1'b1;
    tick(3);
    n_cmp++;
    if (q16 !== 4'd5) begin
      n_bad++; $display("FAIL mid_setup5: got %0d want 5", q16);
    end
    rst = 1'b1; load = 1'b1; d = 4'd9;
    tick();
    n_cmp++;
    if (q16 !== 4'd0 || bo16 !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset: got cnt=%0d bo=%b want cnt=0 bo=1", q16, bo16);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    n_cmp++;
    if (q16 !== 4'd15) begin
      n_bad++; $display("FAIL mid_release: got %0d want 15", q16);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; d = 4'd0;
    dec_rst = 1'b1; dec_en = 1'b0; dec_load = 1'b0; dec_d = 4'd0;
    cas_rst = 1'b1; lo_en = 1'b0;
    test_reset();
    test_count();
    test_load();
    test_load_vs_en();
    test_decade();
    test_cascade();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
